dca_engine: RTL and testbench
=============================

// Module: dca_engine
// PURPOSE
//  Direct-cache-access mover between the NIC packet buffer and the Aquila D-cache DCA port.
//  Consumes core DCA commands (dca_req/cmd/addr/len) and moves whole 256-bit lines.
//  Drives the D-cache n_dca_* port, which is the block downstream of this engine.
//  Supports buffer->cache (RX inject) and cache->buffer (TX extract); one command at a time.
// PARAMETERS
//  CLSIZE      256  cache-line width in bits (LINE_BYTES = CLSIZE/8 = 32)
//  BUF_AW      9    packet-buffer line-address width (512 lines)
//  MAX_LINES   512  largest accepted transfer, in lines
// PORTS
//  clk_i        in   1       system clock
//  rst_ni       in   1       asynchronous active-low reset
//  dca_req_i    in   1       command valid from core
//  dca_ready_o  out  1       engine idle / command accepted when req&&ready
//  dca_cmd_i    in   2       01 = buf->cache write, 10 = cache->buf read, 00/11 = no-op
//  dca_addr_i   in   32      cache byte address (bits[4:0] ignored, forced 0)
//  dca_len_i    in   32      transfer length in bytes
//  dca_done_o   out  1       one-cycle pulse at command completion
//  dc_addr_o    out  32      D-cache line address
//  dc_data_o    out  CLSIZE  line to D-cache
//  dc_data_i    in   CLSIZE  line from D-cache
//  dc_strobe_o  out  1       D-cache request
//  dc_we_o      out  1       1 = write line into cache
//  dc_ready_i   in   1       D-cache completion, valid only while dc_strobe_o=1
//  buf_en_o     out  1       packet-buffer access enable
//  buf_we_o     out  1       packet-buffer write
//  buf_addr_o   out  BUF_AW  packet-buffer line index
//  buf_data_o   out  CLSIZE  line to buffer
//  buf_data_i   in   CLSIZE  line from buffer (1-cycle read latency)
//  dca_err_o    out  1       sticky error (DCA_ERR_CHECK_EN only, else tied 0)
// BEHAVIOUR
//  Reset: state IDLE; dca_ready_o=1; all strobes, enables, done and err are 0; addr/data outputs are 0.
//  Accept: on req&&ready&&cmd in {01,10}, latch addr&~31 and nlines = len[31:5] + |len[4:0].
//    Buffer index restarts at 0 and ready drops the next cycle.
//  No-op: cmd 00/11 or nlines==0 -> no transfer; dca_done_o pulses the cycle after acceptance; ready stays 1.
//  FSM: IDLE, BRD, CWR, CRD, BWR, DONE.
//   Write (01): BRD (buf_en=1, 1 cycle) -> CWR (dc_strobe=1, dc_we=1, data=buf_data_i registered).
//     Hold CWR until dc_ready_i; then advance to the next line or DONE.
//   Read (10): CRD (strobe=1, we=0) until dc_ready_i, capturing dc_data_i -> BWR (buf_en=buf_we=1, 1 cycle).
//     Then advance to the next line or DONE.
//   DONE: dca_done_o=1 for one cycle, then IDLE with ready=1.
//  Handshake: dc_strobe_o, dc_addr_o and dc_data_o stay stable until dc_ready_i is sampled high.
//    Strobe deasserts the cycle after dc_ready_i, giving at least 1 idle cycle between lines.
//    dc_ready_i while strobe=0 is ignored.
//  Per line: dc_addr += 32 (mod 2^32 wrap); buf_addr += 1 (mod 2^BUF_AW wrap); nlines -= 1.
//    The final line is the one issued when nlines==1.
//  Latency per line: write = 1 + Tcache cycles; read = Tcache + 1 cycles.
//  req while busy: ignored (ready=0), not queued.
//  Reset mid-transfer: immediate return to IDLE; the open cache request is abandoned.
//    No done pulse is generated.
// CONFIGURATION
//  `DCA_ERR_CHECK_EN defined: on acceptance, reject (no transfer) and set dca_err_o when any of these hold:
//    nlines > MAX_LINES; start/end address outside 0x8000_0000-0xBFFF_FFFF; addr[4:0]!=0.
//    A rejected command still pulses done. dca_err_o clears on the next accepted valid command.
//  Not defined: no checks; dca_err_o tied 0; addresses wrap silently.
// STRUCTURE
//  dca_pkg: DCA_CMD_NOP/WR/RD/RSV encodings, dca_state_e, LINE_BYTES, LINE_SHIFT=5.
//  Single module; no sub-module. The line counter and address incrementers are inline.
// TESTING
//  1. Write cmd=01, addr=0x8000_0040, len=64, buffer lines 0/1=A/B, dc_ready after 3 cycles
//     -> dc writes A@0x8000_0040 and B@0x8000_0060; one done pulse; ready=1.
//  2. Read cmd=10, addr=0x8000_1000, len=33 -> 2 cache reads; buffer lines 0,1 written with
//     returned data; buf_we pulses exactly twice.
//  3. len=0 or cmd=11 -> no dc_strobe or buf_en activity; done pulses one cycle after acceptance.
//  4. Second req during busy -> ignored; only the first command's lines move.
//  5. rst_ni low during a CWR hold -> strobe=0 asynchronously; no done pulse; ready=1 after release.
//  6. With DCA_ERR_CHECK_EN: addr=0xC000_0000, len=32 -> err=1, no strobe, done pulses once.
//     A following valid command clears err.

Source files
------------

// File: rtl/dca_pkg.sv
// Shared constants for the DCA line mover: command encodings, FSM state codes and the
// length-to-line-count helper.
package dca_pkg;

  localparam int unsigned LINE_BYTES = 32;
  localparam int unsigned LINE_SHIFT = 5;

  localparam logic [1:0] DCA_CMD_NOP = 2'b00;
  localparam logic [1:0] DCA_CMD_WR  = 2'b01;
  localparam logic [1:0] DCA_CMD_RD  = 2'b10;
  localparam logic [1:0] DCA_CMD_RSV = 2'b11;

  typedef logic [2:0] dca_state_e;

  localparam dca_state_e ST_IDLE = 3'd0;
  localparam dca_state_e ST_BRD  = 3'd1;
  localparam dca_state_e ST_CWR  = 3'd2;
  localparam dca_state_e ST_CRD  = 3'd3;
  localparam dca_state_e ST_BWR  = 3'd4;
  localparam dca_state_e ST_DONE = 3'd5;

  // Whole lines needed to cover len bytes; a partial trailing line counts as a full one.
  function automatic logic [27:0] len_to_lines(input logic [31:0] len);
    return {1'b0, len[31:LINE_SHIFT]} + 28'(|len[LINE_SHIFT-1:0]);
  endfunction

endpackage

// File: rtl/dca_engine.sv
// Direct-cache-access mover between the NIC packet buffer and the D-cache DCA port.
// Moves whole lines, one command at a time: buffer->cache (write) or cache->buffer (read).
// Optional build macro DCA_ERR_CHECK_EN enables range/alignment/length checking with a
// sticky error flag; without it dca_err_o is tied low and addresses wrap silently.
module dca_engine
  import dca_pkg::*;
#(
  parameter int unsigned CLSIZE    = 256,
  parameter int unsigned BUF_AW    = 9,
  parameter int unsigned MAX_LINES = 512
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              dca_req_i,
  output logic              dca_ready_o,
  input  logic [1:0]        dca_cmd_i,
  input  logic [31:0]       dca_addr_i,
  input  logic [31:0]       dca_len_i,
  output logic              dca_done_o,
  output logic [31:0]       dc_addr_o,
  output logic [CLSIZE-1:0] dc_data_o,
  input  logic [CLSIZE-1:0] dc_data_i,
  output logic              dc_strobe_o,
  output logic              dc_we_o,
  input  logic              dc_ready_i,
  output logic              buf_en_o,
  output logic              buf_we_o,
  output logic [BUF_AW-1:0] buf_addr_o,
  output logic [CLSIZE-1:0] buf_data_o,
  input  logic [CLSIZE-1:0] buf_data_i,
  output logic              dca_err_o
);

  dca_state_e        state_q, state_d;
  logic [31:0]       dc_addr_q, dc_addr_d;
  logic [BUF_AW-1:0] buf_addr_q, buf_addr_d;
  logic [27:0]       nlines_q, nlines_d;
  logic [CLSIZE-1:0] line_q, line_d;
  logic              first_q, first_d;     // first CWR cycle: buffer read data is on buf_data_i
  logic              nop_done_q, nop_done_d;

  logic        accept;
  logic        cmd_valid;
  logic        reject;
  logic        last_line;
  logic [27:0] req_lines;
  logic [31:0] req_addr;

  assign req_lines = len_to_lines(dca_len_i);
  assign req_addr  = {dca_addr_i[31:LINE_SHIFT], {LINE_SHIFT{1'b0}}};
  assign accept    = dca_req_i && (state_q == ST_IDLE);
  assign cmd_valid = (dca_cmd_i == DCA_CMD_WR) || (dca_cmd_i == DCA_CMD_RD);
  assign last_line = (nlines_q == 28'd1);

`ifdef DCA_ERR_CHECK_EN
  logic        err_q, err_d;
  logic [32:0] end_addr;

  assign end_addr = {1'b0, req_addr} + {req_lines, 5'b0} - 33'd1;
  assign reject   = (32'(req_lines) > MAX_LINES) || (dca_addr_i[4:0] != 5'b0) ||
                    (req_addr[31:30] != 2'b10) || (end_addr[32:30] != 3'b010);

  // Error flag takes the verdict of every accepted, non-empty transfer command
  always_comb begin
    err_d = err_q;
    if (accept && cmd_valid && (req_lines != 28'd0)) begin
      err_d = reject;
    end
  end

  // Sticky error register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign dca_err_o = err_q;
`else
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^dca_addr_i[4:0];
  assign reject          = 1'b0;
  assign dca_err_o       = 1'b0;
`endif

  // Transfer FSM plus inline line counter and address incrementers
  always_comb begin
    state_d    = state_q;
    dc_addr_d  = dc_addr_q;
    buf_addr_d = buf_addr_q;
    nlines_d   = nlines_q;
    line_d     = line_q;
    first_d    = 1'b0;
    nop_done_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (cmd_valid && (req_lines != 28'd0) && !reject) begin
            dc_addr_d  = req_addr;
            buf_addr_d = '0;
            nlines_d   = req_lines;
            state_d    = (dca_cmd_i == DCA_CMD_WR) ? ST_BRD : ST_CRD;
          end else begin
            // Nothing to move: acknowledge without leaving IDLE
            nop_done_d = 1'b1;
          end
        end
      end
      ST_BRD: begin
        first_d = 1'b1;
        state_d = ST_CWR;
      end
      ST_CWR: begin
        if (first_q) begin
          line_d = buf_data_i;
        end
        if (dc_ready_i) begin
          dc_addr_d  = dc_addr_q + 32'(LINE_BYTES);
          buf_addr_d = buf_addr_q + BUF_AW'(1);
          nlines_d   = nlines_q - 28'd1;
          state_d    = last_line ? ST_DONE : ST_BRD;
        end
      end
      ST_CRD: begin
        if (dc_ready_i) begin
          line_d  = dc_data_i;
          state_d = ST_BWR;
        end
      end
      ST_BWR: begin
        dc_addr_d  = dc_addr_q + 32'(LINE_BYTES);
        buf_addr_d = buf_addr_q + BUF_AW'(1);
        nlines_d   = nlines_q - 28'd1;
        state_d    = last_line ? ST_DONE : ST_CRD;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any open cache request
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      dc_addr_q  <= '0;
      buf_addr_q <= '0;
      nlines_q   <= '0;
      line_q     <= '0;
      first_q    <= 1'b0;
      nop_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dc_addr_q  <= dc_addr_d;
      buf_addr_q <= buf_addr_d;
      nlines_q   <= nlines_d;
      line_q     <= line_d;
      first_q    <= first_d;
      nop_done_q <= nop_done_d;
    end
  end

  assign dca_ready_o = (state_q == ST_IDLE);
  assign dca_done_o  = (state_q == ST_DONE) || nop_done_q;
  assign dc_strobe_o = (state_q == ST_CWR) || (state_q == ST_CRD);
  assign dc_we_o     = (state_q == ST_CWR);
  assign dc_addr_o   = dc_addr_q;
  // Buffer data arrives one cycle after BRD; forward it, then hold the captured copy
  assign dc_data_o   = ((state_q == ST_CWR) && first_q) ? buf_data_i : line_q;
  assign buf_en_o    = (state_q == ST_BRD) || (state_q == ST_BWR);
  assign buf_we_o    = (state_q == ST_BWR);
  assign buf_addr_o  = buf_addr_q;
  assign buf_data_o  = line_q;

endmodule

// File: tb/tb_dca_engine.sv
// Scoreboard bench for dca_engine: a command-level reference model pushes the expected
// cache transactions, buffer writes and done pulses; a monitor pops and compares them.
`timescale 1ns/1ps
module tb_dca_engine;

  localparam int CL = 256;

  typedef struct packed {
    logic [31:0]   addr;
    logic          we;
    logic [CL-1:0] data;
  } dc_txn_t;

  typedef struct packed {
    logic [8:0]    idx;
    logic [CL-1:0] data;
  } bw_txn_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          dca_req = 1'b0;
  logic          dca_ready;
  logic [1:0]    dca_cmd = 2'b00;
  logic [31:0]   dca_addr = '0;
  logic [31:0]   dca_len = '0;
  logic          dca_done;
  logic [31:0]   dc_addr;
  logic [CL-1:0] dc_data_o;
  logic [CL-1:0] dc_rdata = '0;
  logic          dc_strobe;
  logic          dc_we;
  logic          dc_ready = 1'b0;
  logic          buf_en;
  logic          buf_we;
  logic [8:0]    buf_addr;
  logic [CL-1:0] buf_data_o;
  logic [CL-1:0] buf_rdata = '0;
  logic          dca_err;

  int n_cmp  = 0;
  int n_fail = 0;

  dc_txn_t exp_dc[$];
  bw_txn_t exp_bw[$];
  int      exp_done_q[$];
  logic    exp_err = 1'b0;

  logic [CL-1:0] bmem   [512];
  logic [CL-1:0] ref_buf[512];
  logic          filled = 1'b0;
  logic [31:0]   salt;

  int   wait_cnt   = 0;
  bit   acked      = 0;
  bit   hold_ack   = 0;
  int   fixed_wait = -1;

  always #5 clk = ~clk;

  dca_engine dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .dca_req_i  (dca_req),
    .dca_ready_o(dca_ready),
    .dca_cmd_i  (dca_cmd),
    .dca_addr_i (dca_addr),
    .dca_len_i  (dca_len),
    .dca_done_o (dca_done),
    .dc_addr_o  (dc_addr),
    .dc_data_o  (dc_data_o),
    .dc_data_i  (dc_rdata),
    .dc_strobe_o(dc_strobe),
    .dc_we_o    (dc_we),
    .dc_ready_i (dc_ready),
    .buf_en_o   (buf_en),
    .buf_we_o   (buf_we),
    .buf_addr_o (buf_addr),
    .buf_data_o (buf_data_o),
    .buf_data_i (buf_rdata),
    .dca_err_o  (dca_err)
  );

  function automatic logic [CL-1:0] init_line(input int i);
    logic [31:0] w;
    w = (32'(i) * 32'h9E37_79B9) ^ salt;
    return {4{w, ~w + 32'(i)}};
  endfunction

  function automatic logic [CL-1:0] cline(input logic [31:0] a);
    return {a, ~a, a ^ salt, a + salt, {a[15:0], a[31:16]}, a ^ 32'h1357_9BDF, salt, a * 3};
  endfunction

  task automatic chk(input string name, input logic [CL-1:0] act, input logic [CL-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic fail_evt(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: got event want none", name);
  endtask

  // Packet buffer with one-cycle read latency
  always @(posedge clk) begin
    if (!filled) begin
      for (int i = 0; i < 512; i++) bmem[i] <= init_line(i);
      filled <= 1'b1;
    end else begin
      if (buf_en && !buf_we) buf_rdata <= bmem[buf_addr];
      if (buf_en && buf_we) bmem[buf_addr] <= buf_data_o;
    end
  end

  // D-cache responder: random latency, plus stray dc_ready while no request is open
  always @(posedge clk) begin
    #1;
    if (dc_strobe && !acked && !hold_ack) begin
      if (wait_cnt == 0) begin
        dc_ready = 1'b1;
        acked    = 1;
        dc_rdata = cline(dc_addr);
      end else begin
        dc_ready = 1'b0;
        wait_cnt--;
      end
    end else if (!dc_strobe) begin
      acked    = 0;
      wait_cnt = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
      dc_ready = ($urandom_range(0, 7) == 0);
      dc_rdata = {8{$urandom}};
    end else begin
      dc_ready = 1'b0;
    end
  end

  // Monitor: pops expectations whenever the DUT presents a transaction
  logic          pend = 1'b0;
  logic [31:0]   prev_addr;
  logic          prev_we;
  logic [CL-1:0] prev_data;
  bit            chk_rdy = 0;
  int            done_hits = 0;

  always @(negedge clk) begin
    dc_txn_t t;
    bw_txn_t b;
    if (!rst_n) begin
      pend    = 1'b0;
      chk_rdy = 0;
    end else begin
      if (chk_rdy) begin
        chk("ready_after_done", CL'(dca_ready), CL'(1));
        chk_rdy = 0;
      end
      if (pend) begin
        if (!dc_strobe) fail_evt("strobe_dropped_early");
        else begin
          chk("hold_addr", CL'(dc_addr), CL'(prev_addr));
          chk("hold_we", CL'(dc_we), CL'(prev_we));
          if (prev_we) chk("hold_data", dc_data_o, prev_data);
        end
      end
      if (dc_strobe && dc_ready) begin
        if (exp_dc.size() == 0) fail_evt("unexpected_dc_txn");
        else begin
          t = exp_dc.pop_front();
          chk("dc_addr", CL'(dc_addr), CL'(t.addr));
          chk("dc_we", CL'(dc_we), CL'(t.we));
          if (t.we) chk("dc_wdata", dc_data_o, t.data);
        end
      end
      pend      = dc_strobe && !dc_ready;
      prev_addr = dc_addr;
      prev_we   = dc_we;
      prev_data = dc_data_o;
      if (buf_en && buf_we) begin
        if (exp_bw.size() == 0) fail_evt("unexpected_buf_write");
        else begin
          b = exp_bw.pop_front();
          chk("buf_waddr", CL'(buf_addr), CL'(b.idx));
          chk("buf_wdata", buf_data_o, b.data);
        end
      end
      if (dca_done) begin
        done_hits++;
        if (exp_done_q.size() == 0) fail_evt("unexpected_done");
        else void'(exp_done_q.pop_front());
        chk_rdy = 1;
      end
    end
  end

  // Reference model: derives the whole command outcome from its arguments
  task automatic model(input logic [1:0] cmd, input logic [31:0] addr, input logic [31:0] len,
                       output bit moves);
    longint      nl;
    logic [31:0] a;
    int          idx;
    bit          valid;
    bit          rej;
    nl    = (longint'(len) + 31) / 32;
    valid = ((cmd == 2'b01) || (cmd == 2'b10)) && (nl > 0);
    rej   = 0;
`ifdef DCA_ERR_CHECK_EN
    if (valid) begin
      longint s;
      longint e;
      s   = longint'(addr) / 32 * 32;
      e   = s + nl * 32 - 1;
      rej = (nl > 512) || (addr % 32 != 0) || (s < 64'h8000_0000) || (e > 64'hBFFF_FFFF);
      exp_err = rej;
    end
`endif
    moves = valid && !rej;
    if (moves) begin
      for (longint i = 0; i < nl; i++) begin
        a   = (addr / 32 * 32) + 32'(i * 32);
        idx = int'(i % 512);
        if (cmd == 2'b01) begin
          exp_dc.push_back('{a, 1'b1, ref_buf[idx]});
        end else begin
          exp_dc.push_back('{a, 1'b0, '0});
          exp_bw.push_back('{9'(idx), cline(a)});
          ref_buf[idx] = cline(a);
        end
      end
    end
    exp_done_q.push_back(1);
  endtask

  // Issue one command and wait for its completion; optional re-request while busy
  task automatic run_cmd(input logic [1:0] cmd, input logic [31:0] addr, input logic [31:0] len,
                         input bit busy_poke, input int budget);
    bit moves;
    int n;
    model(cmd, addr, len, moves);
    n = 0;
    while (!dca_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!dca_ready) begin
      fail_evt("timeout_ready");
      return;
    end
    dca_req  = 1'b1;
    dca_cmd  = cmd;
    dca_addr = addr;
    dca_len  = len;
    @(negedge clk);
    if (moves) chk("ready_drop", CL'(dca_ready), CL'(0));
    else begin
      chk("nop_ready_stays", CL'(dca_ready), CL'(1));
      chk("nop_done_next_cycle", CL'(dca_done), CL'(1));
    end
    if (busy_poke && moves) begin
      dca_cmd  = 2'b10;
      dca_addr = 32'h8000_3000;
      dca_len  = 32'd96;
      @(negedge clk);
      chk("busy_ready_low", CL'(dca_ready), CL'(0));
    end
    dca_req = 1'b0;
    n = 0;
    while (!dca_done && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!dca_done) fail_evt("timeout_done");
    @(negedge clk);
    chk("err_flag", CL'(dca_err), CL'(exp_err));
  endtask

  initial begin
    #800_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit     dummy;
    int     n;
    int     len;
    salt = $urandom;
    for (int i = 0; i < 512; i++) ref_buf[i] = init_line(i);
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst_ready", CL'(dca_ready), CL'(1));
    chk("rst_strobe", CL'(dc_strobe), CL'(0));
    chk("rst_buf_en", CL'(buf_en), CL'(0));
    chk("rst_done", CL'(dca_done), CL'(0));
    chk("rst_err", CL'(dca_err), CL'(0));
    chk("rst_dc_addr", CL'(dc_addr), CL'(0));
    chk("rst_dc_data", dc_data_o, '0);
    chk("rst_buf_addr", CL'(buf_addr), CL'(0));
    chk("rst_buf_data", buf_data_o, '0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Two-line write with a fixed 3-cycle cache latency
    fixed_wait = 2;
    run_cmd(2'b01, 32'h8000_0040, 32'd64, 0, 60);
    fixed_wait = -1;
    // Two-line read from a 33-byte length
    run_cmd(2'b10, 32'h8000_1000, 32'd33, 0, 60);
    // Empty and reserved commands
    run_cmd(2'b01, 32'h8000_0000, 32'd0, 0, 5);
    run_cmd(2'b11, 32'h8000_0000, 32'd64, 0, 5);
    run_cmd(2'b00, 32'h8000_0000, 32'd64, 0, 5);
    // Request while busy must not be queued
    run_cmd(2'b01, 32'h8000_2000, 32'd64, 1, 60);
    run_cmd(2'b10, 32'h8000_2400, 32'd96, 1, 80);
`ifndef DCA_ERR_CHECK_EN
    // Address wrap across 2^32 and buffer index wrap past 512 lines
    run_cmd(2'b10, 32'hFFFF_FFE7, 32'd40, 0, 60);
    run_cmd(2'b01, 32'h8000_0000, 32'd514 * 32, 0, 514 * 8 + 50);
`else
    // Rejected command: out of range, still completes with done
    run_cmd(2'b01, 32'hC000_0000, 32'd32, 0, 5);
    chk("err_set_on_reject", CL'(dca_err), CL'(1));
    run_cmd(2'b01, 32'h8000_0100, 32'd32, 0, 40);
    chk("err_cleared", CL'(dca_err), CL'(0));
    run_cmd(2'b10, 32'h8000_0104, 32'd32, 0, 5);
    run_cmd(2'b10, 32'hBFFF_FFE0, 32'd64, 0, 5);
    run_cmd(2'b01, 32'h8000_0000, 32'd513 * 32, 0, 5);
`endif

    // Randomized commands
    for (int k = 0; k < 25; k++) begin
      logic [1:0]  c;
      logic [31:0] a;
      c   = ($urandom_range(0, 9) == 0) ? 2'(($urandom_range(0, 1) == 0) ? 0 : 3)
                                        : 2'($urandom_range(1, 2));
      a   = 32'h8000_0000 + 32'($urandom_range(0, 4095)) * 32 + 32'($urandom_range(0, 31));
      len = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 224));
      run_cmd(c, a, 32'(len), bit'($urandom_range(0, 1)), 40 + (len / 32 + 1) * 12);
    end

    // Reset while a cache write is held open
    hold_ack = 1;
    dca_req  = 1'b1;
    dca_cmd  = 2'b01;
    dca_addr = 32'h8000_0200;
    dca_len  = 32'd32;
    @(negedge clk);
    dca_req = 1'b0;
    n = 0;
    while (!dc_strobe && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rst_hold_strobe_seen", CL'(dc_strobe), CL'(1));
    repeat (2) @(negedge clk);
    done_hits = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_strobe", CL'(dc_strobe), CL'(0));
    chk("rst_async_ready", CL'(dca_ready), CL'(1));
    chk("rst_async_done", CL'(dca_done), CL'(0));
    @(negedge clk);
    #2 rst_n = 1'b1;
    hold_ack = 0;
    repeat (6) @(negedge clk);
    chk("rst_no_done", CL'(done_hits), CL'(0));
    chk("rst_ready_after", CL'(dca_ready), CL'(1));
    run_cmd(2'b10, 32'h8000_0300, 32'd64, 0, 60);

    repeat (4) @(negedge clk);
    chk("dc_queue_empty", CL'(exp_dc.size()), CL'(0));
    chk("bw_queue_empty", CL'(exp_bw.size()), CL'(0));
    chk("done_queue_empty", CL'(exp_done_q.size()), CL'(0));
    dummy = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
